// File: rtl/elpis_io_pkg.sv
// Shared definitions for the Elpis core I/O path.
//  ELPIS_DATA_W  : width of a print word
//  ELPIS_N_CORES : default number of cores feeding the print path
//  id_width()    : bits needed to tag a word with its source core (min 1)
package elpis_io_pkg;

    localparam int ELPIS_DATA_W  = 32;
    localparam int ELPIS_N_CORES = 4;

    function automatic int id_width(input int n_cores);
        return (n_cores > 1) ? $clog2(n_cores) : 1;
    endfunction

endpackage

// File: rtl/print_fifo.sv
// Synchronous first-word-fall-through FIFO for tagged print words.
//  clk, reset : clock, synchronous active-low reset (empties the FIFO)
//  push       : write push_data this cycle (ignored when full)
//  push_data  : entry to store
//  pop        : drop the head entry this cycle (ignored when empty)
//  head       : current head entry, 0 when empty
//  full/empty : occupancy flags
//  count      : occupancy, 0..DEPTH
module print_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Storage is never reset, so mask the head to keep outputs clean when empty.
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers are exactly log2(DEPTH) wide and wrap by overflow; occupancy
    // is kept in its own counter so full and empty are unambiguous.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_print_arbiter_rr.sv
// Round-robin print arbiter for N Elpis cores.
// Captures at most one core request per cycle into a tagged FWFT FIFO and
// drains it to chip_controller with a valid/ready handshake.
//  clk, reset       : clock, synchronous active-low reset
//  req_core         : per-core level request, held until acked
//  data_core        : core i word at [i*DATA_W +: DATA_W]
//  is_ready_core    : one-cycle ack, the cycle after capture
//  print_hex_enable : FIFO head valid
//  print_output     : FIFO head word (0 when empty)
//  print_core_id    : FIFO head source core (0 when empty)
//  print_ready      : consumer takes the head this cycle
//  fifo_count       : FIFO occupancy
module io_print_arbiter_rr
    import elpis_io_pkg::*;
#(
    parameter int  N_CORES = ELPIS_N_CORES,
    parameter int  DATA_W  = ELPIS_DATA_W,
    parameter int  DEPTH   = 8,
    localparam int ID_W    = id_width(N_CORES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CORES-1:0]          req_core,
    input  logic [N_CORES*DATA_W-1:0]   data_core,
    output logic [N_CORES-1:0]          is_ready_core,
    output logic                        print_hex_enable,
    output logic [DATA_W-1:0]           print_output,
    output logic [ID_W-1:0]             print_core_id,
    input  logic                        print_ready,
    output logic [$clog2(DEPTH+1)-1:0]  fifo_count
);

    logic [N_CORES-1:0]     mask, eligible, grant_oh;
    logic [ID_W-1:0]        rr_ptr, winner, scan_idx;
    logic                   found, grant;
    logic                   fifo_full, fifo_empty;
    logic [ID_W+DATA_W-1:0] fifo_head;

    assign eligible = req_core & ~mask;

    // Scan from the core after the last winner, wrapping; first hit wins.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int k = 1; k <= N_CORES; k++) begin
            scan_idx = ID_W'((int'(rr_ptr) + k) % N_CORES);
            if (!found && eligible[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
        // A full FIFO blocks the grant outright, even if it pops this cycle.
        grant    = found && !fifo_full;
        grant_oh = '0;
        if (grant) grant_oh[winner] = 1'b1;
    end

    // The ack and the mask are the same pulse: the acked core is blocked for
    // exactly the cycle it sees its ack, so dropping req then is safe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr <= ID_W'(N_CORES - 1);
            mask   <= '0;
        end else begin
            mask <= grant_oh;
            if (grant) rr_ptr <= winner;
        end
    end

    assign is_ready_core = mask;

    print_fifo #(
        .W     (ID_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (grant),
        .push_data ({winner, data_core[winner*DATA_W +: DATA_W]}),
        .pop       (print_ready && !fifo_empty),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign print_hex_enable = !fifo_empty;
    assign print_output     = fifo_head[DATA_W-1:0];
    assign print_core_id    = fifo_head[DATA_W +: ID_W];

endmodule

// File: tb/tb_io_print_arbiter_rr.sv
module tb_io_print_arbiter_rr;

    localparam int N = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  req_core = '0;
    logic [N*DW-1:0] data_core = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    logic [N-1:0]  is_ready_core;
    logic          print_hex_enable;
    logic [DW-1:0] print_output;
    logic [1:0]    print_core_id;
    logic          print_ready = 1'b0;
    logic [3:0]    fifo_count;

    io_print_arbiter_rr #(.N_CORES(N), .DATA_W(DW), .DEPTH(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_core         (req_core),
        .data_core        (data_core),
        .is_ready_core    (is_ready_core),
        .print_hex_enable (print_hex_enable),
        .print_output     (print_output),
        .print_core_id    (print_core_id),
        .print_ready      (print_ready),
        .fifo_count       (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input int id);
        exp_t e;
        e.id   = id;
        e.data = 32'hA0 + 32'(id);
        exp_q.push_back(e);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_en"},  64'(print_hex_enable), 64'd0);
        chk({name, "_out"}, 64'(print_output), 64'd0);
        chk({name, "_id"},  64'(print_core_id), 64'd0);
        chk({name, "_ack"}, 64'(is_ready_core), 64'd0);
        chk({name, "_cnt"}, 64'(fifo_count), 64'd0);
    endtask

    // Monitor: a pop happens at the next posedge whenever the head is valid
    // and the consumer is ready (and reset is not about to discard it).
    always @(negedge clk) begin
        if (reset && print_hex_enable && print_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected: got id %0d data %0h expected nothing", print_core_id, print_output);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (int'(print_core_id) != e.id || print_output !== e.data) begin
                    n_err++;
                    $display("FAIL pop_order: got id %0d data %0h expected id %0d data %0h",
                             print_core_id, print_output, e.id, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. reset held 3 cycles with all cores requesting
        req_core = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("reset");
        end
        reset = 1'b1;
        print_ready = 1'b1;
        chk("ack_after_release", 64'(is_ready_core), 64'd0);

        // 2. all cores requesting: grant order 0,1,2,3,0,...
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_ack", 64'(is_ready_core), 64'(4'b0001 << (k % 4)));
            expect_word(k % 4);
        end
        req_core = '0;
        repeat (3) tick();
        chk("rr_drained_cnt", 64'(fifo_count), 64'd0);
        chk("rr_drained_ack", 64'(is_ready_core), 64'd0);

        // 3. core 2 holds req one cycle past its ack: single capture
        req_core = 4'b0100;
        tick();
        chk("c2_ack", 64'(is_ready_core), 64'b0100);
        expect_word(2);
        tick();
        chk("c2_masked", 64'(is_ready_core), 64'd0);
        req_core = '0;
        tick();
        chk("c2_no_recapture", 64'(is_ready_core), 64'd0);
        // held two cycles past the ack: captured again
        req_core = 4'b0100;
        tick();
        chk("c2b_ack", 64'(is_ready_core), 64'b0100);
        expect_word(2);
        tick();
        chk("c2b_masked", 64'(is_ready_core), 64'd0);
        tick();
        chk("c2b_ack2", 64'(is_ready_core), 64'b0100);
        expect_word(2);
        req_core = '0;
        tick();
        chk("c2b_done", 64'(is_ready_core), 64'd0);
        repeat (3) tick();
        chk("c2_drained", 64'(fifo_count), 64'd0);

        // 4. stalled consumer: fill to 8, last winner was core 2 -> start at 3
        print_ready = 1'b0;
        req_core = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("fill_ack", 64'(is_ready_core), 64'(4'b0001 << ((3 + k) % 4)));
            expect_word((3 + k) % 4);
        end
        chk("full_cnt", 64'(fifo_count), 64'd8);
        chk("full_en", 64'(print_hex_enable), 64'd1);
        tick();
        chk("full_no_ack1", 64'(is_ready_core), 64'd0);
        tick();
        chk("full_no_ack2", 64'(is_ready_core), 64'd0);
        chk("full_cnt2", 64'(fifo_count), 64'd8);

        // 5. pop one while full: no push this cycle, push next cycle
        print_ready = 1'b1;
        tick();
        chk("pop_cnt7", 64'(fifo_count), 64'd7);
        chk("pop_no_ack", 64'(is_ready_core), 64'd0);
        print_ready = 1'b0;
        tick();
        chk("refill_cnt8", 64'(fifo_count), 64'd8);
        chk("refill_ack", 64'(is_ready_core), 64'b1000);
        expect_word(3);
        req_core = '0;
        tick();
        chk("refill_ack_gone", 64'(is_ready_core), 64'd0);
        print_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("drain_cnt", 64'(fifo_count), 64'(7 - k));
        end

        // 6. reset with 5 buffered and an ack pending; last winner was core 3
        print_ready = 1'b0;
        req_core = 4'b1111;
        repeat (5) tick();
        chk("pre_rst_cnt", 64'(fifo_count), 64'd5);
        chk("pre_rst_ack", 64'(is_ready_core), 64'b0001);
        reset = 1'b0;
        tick();
        chk_idle("mid_reset");
        reset = 1'b1;
        print_ready = 1'b1;
        tick();
        chk("post_rst_ack", 64'(is_ready_core), 64'b0001);
        expect_word(0);
        req_core = '0;
        repeat (3) tick();
        chk("post_rst_cnt", 64'(fifo_count), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
